// File: rtl/sincos_cordic.sv
// sincos_cordic: iterative CORDIC sine/cosine generator.
//
// A start pulse in IDLE captures theta (unsigned 4.8, 0x648 = 2*pi), folds it
// into one quadrant, runs ITERATIONS rotation-mode micro-rotations on a 20-bit
// (16 fraction bit) x/y/z datapath, then maps the result back to the original
// quadrant and registers it. done pulses ITERATIONS+2 cycles after acceptance.
//
// Ports:
//   Clk      in   system clock, all state on rising edge
//   Reset    in   synchronous active-high reset
//   start    in   one-cycle request, sampled only in IDLE
//   theta    in   [11:0] unsigned angle, 4.8 fixed point
//   busy     out  high from the cycle after acceptance through the done cycle
//   done     out  one-cycle pulse when sin_out/cos_out update
//   sin_out  out  [11:0] signed 4.8 sine
//   cos_out  out  [11:0] signed 4.8 cosine
//
// Configuration macro: SINCOS_GAIN_COMP_EN
//   defined   -> x starts at K = 0.607253, outputs have unit amplitude
//   undefined -> x starts at 1.0, outputs carry the CORDIC gain (~1.6468)

module sincos_cordic #(
    parameter int unsigned ITERATIONS = 14
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [11:0] theta,
    output logic        busy,
    output logic        done,
    output logic [11:0] sin_out,
    output logic [11:0] cos_out
);

    typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

`ifdef SINCOS_GAIN_COMP_EN
    localparam logic signed [19:0] X_INIT = 20'sh09B75;
`else
    localparam logic signed [19:0] X_INIT = 20'sh10000;
`endif

    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t             state, state_nxt;
    logic [3:0]         iter;
    logic [1:0]         quad, quad_dec;
    logic signed [19:0] x, y, z;
    logic [11:0]        t_red, resid;
    logic signed [19:0] atan_i, sin_map, cos_map;
    logic               load, rotate, update, busy_nxt, done_nxt;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROT;
            ROT:     if (iter == LAST_ITER) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode. busy and done are registered from these so
    // busy stays high through the cycle in which done is asserted.
    always_comb begin
        load     = (state == IDLE) && start;
        rotate   = (state == ROT);
        update   = (state == OUT);
        busy_nxt = (state != IDLE) || start;
        done_nxt = (state == OUT);
    end

    // Single-wrap angle reduction and quadrant fold of the incoming theta
    always_comb begin
        t_red = (theta > 12'h648) ? (theta - 12'h648) : theta;
        if (t_red < 12'h192) begin
            quad_dec = 2'd0;
            resid    = t_red;
        end else if (t_red < 12'h324) begin
            quad_dec = 2'd1;
            resid    = t_red - 12'h192;
        end else if (t_red < 12'h4B6) begin
            quad_dec = 2'd2;
            resid    = t_red - 12'h324;
        end else begin
            quad_dec = 2'd3;
            resid    = t_red - 12'h4B6;
        end
    end

    // atan(2^-i) ROM, 16 fraction bits, rounded
    always_comb begin
        case (iter)
            4'd0:    atan_i = 20'sd51472;
            4'd1:    atan_i = 20'sd30386;
            4'd2:    atan_i = 20'sd16055;
            4'd3:    atan_i = 20'sd8150;
            4'd4:    atan_i = 20'sd4091;
            4'd5:    atan_i = 20'sd2047;
            4'd6:    atan_i = 20'sd1024;
            4'd7:    atan_i = 20'sd512;
            4'd8:    atan_i = 20'sd256;
            4'd9:    atan_i = 20'sd128;
            4'd10:   atan_i = 20'sd64;
            4'd11:   atan_i = 20'sd32;
            4'd12:   atan_i = 20'sd16;
            4'd13:   atan_i = 20'sd8;
            4'd14:   atan_i = 20'sd4;
            4'd15:   atan_i = 20'sd2;
            default: atan_i = '0;
        endcase
    end

    // Undo the quadrant fold
    always_comb begin
        case (quad)
            2'd0:    begin cos_map = x;  sin_map = y;  end
            2'd1:    begin cos_map = -y; sin_map = x;  end
            2'd2:    begin cos_map = -x; sin_map = -y; end
            default: begin cos_map = y;  sin_map = -x; end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            quad    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sin_out <= 12'h000;
            cos_out <= 12'h100;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (load) begin
                x    <= X_INIT;
                y    <= '0;
                z    <= $signed({resid, 8'h00});
                quad <= quad_dec;
                iter <= '0;
            end else if (rotate) begin
                // z >= 0 rotates counter-clockwise, negative z clockwise
                if (!z[19]) begin
                    x <= x - (y >>> iter);
                    y <= y + (x >>> iter);
                    z <= z - atan_i;
                end else begin
                    x <= x + (y >>> iter);
                    y <= y - (x >>> iter);
                    z <= z + atan_i;
                end
                iter <= iter + 4'd1;
            end
            if (update) begin
                sin_out <= 12'(sin_map >>> 8);
                cos_out <= 12'(cos_map >>> 8);
            end
        end
    end

endmodule
